// File: rtl/pc_sequencer.sv
// pc_sequencer: PC/fetch control FSM. Sequences instruction fetches through a
// fixed-latency memory, applies branch/jump/jr redirects and exception entry.
// Strobes decode from the registered state; PC/address/EPC values come from
// datapath registers loaded on the edge that enters the producing state.
module pc_sequencer #(
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] EXC_VECTOR  = 32'h000000FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        redir_req,
  input  logic [1:0]  redir_sel,
  input  logic [31:0] branch_off,
  input  logic [25:0] jump_idx,
  input  logic [31:0] reg_target,
  input  logic        exc_req,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_source_out,
  output logic        pc_wr,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        ir_wr,
  output logic [31:0] epc_out,
  output logic        epc_wr,
  output logic        fetch_done,
  output logic        addr_err,
  output logic        busy
);

  localparam logic [3:0] LAT = MEM_LATENCY[3:0];

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_LOAD, S_REDIR, S_EXC, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  ctr;
  logic [31:0] target;
  logic [31:0] addr_q, src_q, epc_q;
  logic        redir_go, jr_misaligned;

  // Redirect target for the currently presented request
  always_comb begin
    target = reg_target;
    case (redir_sel)
      2'b00:   target = pc_in + (branch_off << 2);
      2'b01:   target = {pc_in[31:28], jump_idx, 2'b00};
      default: target = reg_target;
    endcase
  end

  // sel=11 is reserved: the redirect wins arbitration but does nothing
  assign redir_go      = redir_req && (redir_sel != 2'b11);
  assign jr_misaligned = (redir_sel == 2'b10) && (reg_target[1:0] != 2'b00);

  // Next-state: exception beats everything; new work only starts from IDLE
  always_comb begin
    state_nxt = state;
    if (exc_req) begin
      state_nxt = S_EXC;
    end else begin
      case (state)
        S_IDLE: begin
          if (redir_go)       state_nxt = jr_misaligned ? S_ERR : S_REDIR;
          else if (redir_req) state_nxt = S_IDLE;
          else if (fetch_req) state_nxt = S_REQ;
        end
        S_REQ:   state_nxt = S_WAIT;
        S_WAIT:  if (ctr <= 4'd1) state_nxt = S_LOAD;
        S_LOAD,
        S_REDIR,
        S_EXC,
        S_ERR:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Datapath registers: latency counter, fetch address, next-PC, EPC
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctr    <= '0;
      addr_q <= '0;
      src_q  <= '0;
      epc_q  <= '0;
    end else begin
      if (state == S_REQ)                    ctr <= LAT;
      else if (state == S_WAIT && ctr != '0) ctr <= ctr - 4'd1;

      if (state_nxt == S_REQ) addr_q <= pc_in;

      case (state_nxt)
        S_EXC:   src_q <= EXC_VECTOR;
        S_REDIR: src_q <= target;
        S_LOAD:  src_q <= pc_in + 32'd4;
        default: src_q <= src_q;
      endcase

      if (state_nxt == S_EXC) epc_q <= pc_in;
    end
  end

  assign pc_source_out = src_q;
  assign mem_addr      = addr_q;
  assign epc_out       = epc_q;
  assign pc_wr         = (state == S_LOAD) || (state == S_REDIR) || (state == S_EXC);
  assign mem_rd        = (state == S_REQ);
  assign ir_wr         = (state == S_LOAD);
  assign fetch_done    = (state == S_LOAD);
  assign epc_wr        = (state == S_EXC);
  assign addr_err      = (state == S_ERR);
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: two sequencers (latency 1 and 3) share one stimulus stream.
// A transaction-level model (kind of operation + cycle age since acceptance)
// predicts every output each cycle; directed steps add spot checks.
module tb_pc_sequencer;

  localparam int NONE = 0, FETCH = 1, REDIR = 2, ERR = 3, EXC = 4;
  localparam logic [31:0] EXCV = 32'h000000FF;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, redir_req, exc_req;
  logic [1:0]  redir_sel;
  logic [31:0] branch_off, reg_target, pc_in;
  logic [25:0] jump_idx;

  logic [31:0] src_o[2], addr_o[2], epc_o[2];
  logic        pc_wr_o[2], mem_rd_o[2], ir_wr_o[2], epc_wr_o[2];
  logic        done_o[2], aerr_o[2], busy_o[2];

  int          n_vec = 0, n_err = 0;
  int          lat[2] = '{1, 3};
  int          kind[2], age[2];
  logic [31:0] m_addr[2], m_src[2], m_epc[2];

  always #5 clk = ~clk;

  pc_sequencer #(.MEM_LATENCY(1), .EXC_VECTOR(EXCV)) dut0 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .redir_req(redir_req),
    .redir_sel(redir_sel), .branch_off(branch_off), .jump_idx(jump_idx),
    .reg_target(reg_target), .exc_req(exc_req), .pc_in(pc_in),
    .pc_source_out(src_o[0]), .pc_wr(pc_wr_o[0]), .mem_addr(addr_o[0]),
    .mem_rd(mem_rd_o[0]), .ir_wr(ir_wr_o[0]), .epc_out(epc_o[0]),
    .epc_wr(epc_wr_o[0]), .fetch_done(done_o[0]), .addr_err(aerr_o[0]),
    .busy(busy_o[0]));

  pc_sequencer #(.MEM_LATENCY(3), .EXC_VECTOR(EXCV)) dut1 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .redir_req(redir_req),
    .redir_sel(redir_sel), .branch_off(branch_off), .jump_idx(jump_idx),
    .reg_target(reg_target), .exc_req(exc_req), .pc_in(pc_in),
    .pc_source_out(src_o[1]), .pc_wr(pc_wr_o[1]), .mem_addr(addr_o[1]),
    .mem_rd(mem_rd_o[1]), .ir_wr(ir_wr_o[1]), .epc_out(epc_o[1]),
    .epc_wr(epc_wr_o[1]), .fetch_done(done_o[1]), .addr_err(aerr_o[1]),
    .busy(busy_o[1]));

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
    end
  endtask

  // One clock edge of the reference model for sequencer d
  task automatic model_edge(input int d);
    bit free, last;
    logic [31:0] tgt;
    if (!reset) begin
      kind[d] = NONE; age[d] = 0;
      m_addr[d] = '0; m_src[d] = '0; m_epc[d] = '0;
      return;
    end
    free = (kind[d] == NONE);
    last = (kind[d] == FETCH) ? (age[d] == lat[d] + 2) : (kind[d] != NONE);
    case (redir_sel)
      2'd0:    tgt = pc_in + branch_off * 4;
      2'd1:    tgt = (pc_in & 32'hF000_0000) | ({6'd0, jump_idx} << 2);
      default: tgt = reg_target;
    endcase
    if (exc_req) begin
      kind[d] = EXC; age[d] = 1; m_src[d] = EXCV; m_epc[d] = pc_in;
    end else if (free && redir_req) begin
      if (redir_sel == 2'd3) begin
        kind[d] = NONE;
      end else if (redir_sel == 2'd2 && reg_target[1:0] != 2'b00) begin
        kind[d] = ERR; age[d] = 1;
      end else begin
        kind[d] = REDIR; age[d] = 1; m_src[d] = tgt;
      end
    end else if (free && fetch_req) begin
      kind[d] = FETCH; age[d] = 1; m_addr[d] = pc_in;
    end else if (!free) begin
      if (last) begin
        kind[d] = NONE; age[d] = 0;
      end else begin
        age[d]++;
        if (kind[d] == FETCH && age[d] == lat[d] + 2) m_src[d] = pc_in + 32'd4;
      end
    end
  endtask

  task automatic model_check(input int d);
    bit ld;
    ld = (kind[d] == FETCH) && (age[d] == lat[d] + 2);
    chk("pc_source_out", d, src_o[d],  m_src[d]);
    chk("mem_addr",      d, addr_o[d], m_addr[d]);
    chk("epc_out",       d, epc_o[d],  m_epc[d]);
    chk("pc_wr",      d, {31'd0, pc_wr_o[d]},  {31'd0, kind[d] == EXC || kind[d] == REDIR || ld});
    chk("mem_rd",     d, {31'd0, mem_rd_o[d]}, {31'd0, kind[d] == FETCH && age[d] == 1});
    chk("ir_wr",      d, {31'd0, ir_wr_o[d]},  {31'd0, ld});
    chk("fetch_done", d, {31'd0, done_o[d]},   {31'd0, ld});
    chk("epc_wr",     d, {31'd0, epc_wr_o[d]}, {31'd0, kind[d] == EXC});
    chk("addr_err",   d, {31'd0, aerr_o[d]},   {31'd0, kind[d] == ERR});
    chk("busy",       d, {31'd0, busy_o[d]},   {31'd0, kind[d] != NONE});
  endtask

  // Advance one clock with the currently driven inputs, then check both DUTs
  task automatic cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    model_check(0);
    model_check(1);
    @(negedge clk);
  endtask

  task automatic clr();
    reset = 1'b1; fetch_req = 1'b0; redir_req = 1'b0; exc_req = 1'b0;
    redir_sel = 2'd0; branch_off = '0; jump_idx = '0; reg_target = '0;
  endtask

  task automatic idle(input int n);
    clr();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    clr();
    pc_in = '0;
    for (int d = 0; d < 2; d++) begin
      kind[d] = NONE; age[d] = 0; m_addr[d] = '0; m_src[d] = '0; m_epc[d] = '0;
    end
    @(negedge clk);

    // Reset wins over a simultaneous exception
    reset = 1'b0; exc_req = 1'b1; fetch_req = 1'b1; pc_in = 32'h1234;
    cycle(); cycle();
    chk("rst_busy", 0, {31'd0, busy_o[0]}, 32'd0);
    chk("rst_epc",  0, epc_o[0], 32'd0);

    // First edge out of reset accepts a fetch
    clr(); pc_in = 32'h100; fetch_req = 1'b1;
    cycle();
    chk("f_mem_rd", 0, {31'd0, mem_rd_o[0]}, 32'd1);
    chk("f_addr",   0, addr_o[0], 32'h100);
    fetch_req = 1'b0;
    cycle();
    chk("f_wait_rd", 0, {31'd0, mem_rd_o[0]}, 32'd0);
    cycle();
    chk("f_ir_wr", 0, {31'd0, ir_wr_o[0]}, 32'd1);
    chk("f_done",  0, {31'd0, done_o[0]},  32'd1);
    chk("f_src",   0, src_o[0], 32'h104);
    idle(4);

    // Branch backwards by two words
    pc_in = 32'h104; redir_req = 1'b1; redir_sel = 2'd0; branch_off = 32'hFFFF_FFFE;
    cycle();
    chk("br_src", 0, src_o[0], 32'h0000_00FC);
    chk("br_wr",  0, {31'd0, pc_wr_o[0]}, 32'd1);
    idle(1);
    chk("br_wr_end", 0, {31'd0, pc_wr_o[0]}, 32'd0);

    // Jump keeps the top nibble
    pc_in = 32'h4000_0010; redir_req = 1'b1; redir_sel = 2'd1; jump_idx = 26'h0000100;
    cycle();
    chk("j_src", 0, src_o[0], 32'h4000_0400);
    idle(1);

    // Misaligned jr
    redir_req = 1'b1; redir_sel = 2'd2; reg_target = 32'h202;
    cycle();
    chk("jr_aerr", 0, {31'd0, aerr_o[0]},  32'd1);
    chk("jr_pcwr", 0, {31'd0, pc_wr_o[0]}, 32'd0);
    idle(1);
    chk("jr_aerr_end", 0, {31'd0, aerr_o[0]}, 32'd0);

    // Reserved redirect select is a no-op
    redir_req = 1'b1; redir_sel = 2'd3;
    cycle();
    chk("rsv_busy", 0, {31'd0, busy_o[0]}, 32'd0);
    idle(1);

    // Exception while latency-3 fetch is waiting
    pc_in = 32'h200; fetch_req = 1'b1;
    cycle();
    fetch_req = 1'b0;
    cycle();
    exc_req = 1'b1;
    cycle();
    chk("exc_src",  1, src_o[1], 32'h0000_00FF);
    chk("exc_epc",  1, epc_o[1], 32'h200);
    chk("exc_ir",   1, {31'd0, ir_wr_o[1]}, 32'd0);
    idle(1);
    chk("exc_done", 1, {31'd0, done_o[1]}, 32'd0);
    idle(3);

    // All three requests at once: exception only
    exc_req = 1'b1; redir_req = 1'b1; redir_sel = 2'd1; fetch_req = 1'b1; pc_in = 32'h300;
    cycle();
    chk("all_epcwr", 0, {31'd0, epc_wr_o[0]}, 32'd1);
    idle(1);
    chk("all_idle",  0, {31'd0, busy_o[0]}, 32'd0);

    // Reset in WAIT
    fetch_req = 1'b1; pc_in = 32'h400;
    cycle();
    fetch_req = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    chk("rw_busy", 1, {31'd0, busy_o[1]}, 32'd0);
    chk("rw_addr", 1, addr_o[1], 32'd0);
    idle(6);

    // PC wrap
    pc_in = 32'hFFFF_FFFC; fetch_req = 1'b1;
    cycle();
    fetch_req = 1'b0;
    cycle(); cycle();
    chk("wrap_src", 0, src_o[0], 32'd0);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(63) != 0);
      exc_req    = ($urandom_range(15) == 0);
      redir_req  = ($urandom_range(3) == 0);
      redir_sel  = 2'($urandom_range(3));
      fetch_req  = ($urandom_range(1) == 0);
      if (redir_req && redir_sel == 2'd3) fetch_req = 1'b0;
      branch_off = $urandom();
      jump_idx   = 26'($urandom());
      reg_target = ($urandom_range(1) == 0) ? ($urandom() & 32'hFFFF_FFFC) : $urandom();
      pc_in      = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
